// File: rtl/disp_history_ctrl.sv
// disp_history_ctrl
//   Sequences the seven-segment glyph history that feeds the six HEX digit
//   decoders. Glyphs arrive from the PS/2 parser over a valid/ready handshake
//   and are shifted into a DEPTH-entry history (entry 0 = newest). Scroll
//   pulses move a 6-digit view window over the history. A clear pulse blanks
//   the history one entry per cycle, as if it had a single write port.
//
//   Optional build macro: DISP_HISTORY_BLINK_EN
//     Adds a blink divider (BLINK_DIV cycles per half-period). When the view
//     is at offset 0, the newest digit (window[6:0]) blinks as a cursor.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   RESET       in   synchronous active-high reset
//   glyph       in   7-bit segment bitmap to append
//   glyph_valid in   glyph present
//   glyph_ready out  glyph can be accepted this cycle
//   scroll_up   in   pulse: view older entries
//   scroll_down in   pulse: view newer entries
//   clear       in   pulse: blank the whole history
//   history     out  full history, entry 0 in bits [6:0]
//   window      out  six entries starting at offset, bits [6:0] to HEX0
//   count       out  valid entries stored, saturating at DEPTH
//   offset      out  current view offset in entries
//   busy        out  high while clearing
//
// state  | meaning
// S_IDLE | accepting glyphs and scroll commands
// S_CLEAR| writing BLANK to one entry per cycle, index 0..DEPTH-1

module disp_history_ctrl #(
    parameter int         DEPTH     = 64,
    parameter logic [6:0] BLANK     = 7'h7F,
    parameter int         BLINK_DIV = 25000000
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic [6:0]                   glyph,
    input  logic                         glyph_valid,
    output logic                         glyph_ready,
    input  logic                         scroll_up,
    input  logic                         scroll_down,
    input  logic                         clear,
    output logic [7*DEPTH-1:0]           history,
    output logic [41:0]                  window,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     offset,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH);
    localparam int HW = 7 * DEPTH;

    localparam logic [CW-1:0] COUNT_MAX  = CW'(DEPTH);
    localparam logic [OW-1:0] OFFSET_MAX = OW'(DEPTH - 6);
    localparam logic [OW-1:0] INDEX_LAST = OW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   history_q, history_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic [OW-1:0]   index_q, index_d;
    logic            accept;
    logic [OW-1:0]   scroll_limit;

    // Oldest viewable offset: max(count,6)-6, so a short history never scrolls.
    assign scroll_limit = (count_q >= CW'(6)) ? OW'(count_q - CW'(6)) : '0;

    always_comb begin
        state_d     = state_q;
        history_d   = history_q;
        count_d     = count_q;
        offset_d    = offset_q;
        index_d     = index_q;
        glyph_ready = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                glyph_ready = 1'b1;
                accept      = glyph_valid && !clear;
                if (accept) begin
                    history_d = {history_q[HW-8:0], glyph};
                    if (count_q != COUNT_MAX)
                        count_d = count_q + 1'b1;
                    // Keep the viewed text still while new glyphs push in below it.
                    if (offset_q != '0 && offset_q != OFFSET_MAX)
                        offset_d = offset_q + 1'b1;
                end else if (scroll_up && !scroll_down) begin
                    if (offset_q < scroll_limit)
                        offset_d = offset_q + 1'b1;
                end else if (scroll_down && !scroll_up) begin
                    if (offset_q != '0)
                        offset_d = offset_q - 1'b1;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                history_d[32'(index_q) * 7 +: 7] = BLANK;
                if (index_q == INDEX_LAST)
                    state_d = S_IDLE;
                else
                    index_d = index_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // clear wins over everything, including a restart while already clearing.
        if (clear) begin
            state_d   = S_CLEAR;
            history_d = history_q;
            index_d   = '0;
            count_d   = '0;
            offset_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            history_q <= {DEPTH{BLANK}};
            count_q   <= '0;
            offset_q  <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            history_q <= history_d;
            count_q   <= count_d;
            offset_q  <= offset_d;
            index_q   <= index_d;
        end
    end

    assign history = history_q;
    assign count   = count_q;
    assign offset  = offset_q;

`ifdef DISP_HISTORY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Restarting on accept makes a freshly typed glyph visible at once.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || accept) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        window = history_q[32'(offset_q) * 7 +: 42];
        if (offset_q == '0 && blink_phase)
            window[6:0] = BLANK;
    end
`else
    assign window = history_q[32'(offset_q) * 7 +: 42];
`endif

endmodule

// File: doc/disp_history_ctrl.md
Name: disp_history_ctrl

Overview:
- Sequences the seven-segment history register that feeds the six HEX digit decoders.
- Accepts glyph bitmaps from the PS/2 keyboard parser through a valid/ready handshake and appends them to a DEPTH-entry shift history.
- Arbitrates glyph writes against scroll and clear commands, and presents a 6-digit view window (42 bits) selected by a scroll offset.
- Sits between the ps2 keyboard block and the six per-digit raw display drivers.

Parameters:
- DEPTH, 64: number of 7-bit history entries. Minimum 6. History register width is 7*DEPTH.
- BLANK, 7'h7F: glyph meaning all segments off (active-low segments).
- BLINK_DIV, 25000000: CLOCK_50 cycles per cursor blink half-period. Used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock. All logic is on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- glyph  in  7  segment bitmap to append.
- glyph_valid  in  1  glyph is present.
- glyph_ready  out  1  block can accept a glyph this cycle.
- scroll_up  in  1  single-cycle pulse: view older entries (offset+1).
- scroll_down  in  1  single-cycle pulse: view newer entries (offset-1).
- clear  in  1  single-cycle pulse: blank the whole history.
- history  out  7*DEPTH  full history. Entry 0 is bits [6:0] and is the newest.
- window  out  42  history[offset*7 +: 42]. Bits [6:0] go to HEX0.
- count  out  $clog2(DEPTH+1)  valid entries stored, saturating at DEPTH.
- offset  out  $clog2(DEPTH)  current view offset in entries.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset values:
  - history all BLANK, window all BLANK.
  - count=0, offset=0, busy=0.
  - glyph_ready=1, state=IDLE.
- States: IDLE and CLEAR.
- IDLE:
  - glyph_ready=1.
  - An accept is glyph_valid&&glyph_ready.
  - On accept: history <= {history[7*DEPTH-8:0], glyph}, so the oldest entry is discarded. count <= min(count+1, DEPTH).
  - If offset>0 on accept: offset <= min(offset+1, DEPTH-6), so the viewed text stays put.
  - The update is visible on history, window and count the cycle after the accept (1-cycle latency).
- Scroll, evaluated only in IDLE and only in a cycle with no accept:
  - scroll_up alone: offset+1 if offset < max(count,6)-6, otherwise no change.
  - scroll_down alone: offset-1 if offset>0, otherwise no change.
  - scroll_up and scroll_down together: ignored.
  - Scroll pulses arriving in an accept cycle are dropped, not queued.
- clear:
  - Highest priority, accepted in IDLE or CLEAR.
  - Enters CLEAR with index=0, count<=0, offset<=0, glyph_ready=0, busy=1.
  - A glyph offered in the same cycle as clear is not accepted.
- CLEAR:
  - Writes BLANK to entry[index] once per cycle, index 0..DEPTH-1.
  - Models a single-write-port history, so entries not yet reached keep their old value during CLEAR.
  - After the cycle writing entry DEPTH-1, returns to IDLE. busy=0 and glyph_ready=1 from the next cycle.
  - Total duration is exactly DEPTH cycles.
  - scroll_up/scroll_down are ignored during CLEAR.
  - clear during CLEAR restarts at index 0.
- RESET mid-CLEAR aborts the clear and all registers return to their reset values the next cycle.
- window is combinational from the history and offset registers, with no extra latency.
- Invariant: offset <= DEPTH-6 at all times.

Optional Feature:
- Macro: DISP_HISTORY_BLINK_EN.
- Defined:
  - Adds a BLINK_DIV counter and a blink phase bit. Counter and phase reset to 0.
  - When offset==0 and the phase is 1, window[6:0] is forced to BLANK, giving a blinking newest digit as the cursor.
  - The counter and phase restart on every accept, so a new glyph is visible immediately.
  - history is never affected.
- Undefined: no counter is built and window[6:0] always equals history[offset*7 +: 7].

Test Plan:
- RESET, then glyph 7'h40 valid for 1 cycle -> next cycle history[6:0]=7'h40, count=1, window[13:7]=7'h7F.
- Accept 10 glyphs 7'h00..7'h09, then 3 scroll_up pulses -> offset=3, window[6:0]=7'h06. A further 2 scroll_up -> offset=4 (saturated at count-6). Two scroll_down at once with scroll_up -> unchanged.
- With offset=2, accept glyph 7'h11 with scroll_down high in the same cycle -> offset=3, scroll dropped, window content unchanged.
- DEPTH=64, accept 70 glyphs -> count=64, history[447:441] equals the 7th glyph sent.
- clear pulse with glyph_valid high -> glyph not accepted, busy=1 and glyph_ready=0 for exactly 64 cycles, then history all 7'h7F, count=0, offset=0.
- RESET asserted at CLEAR index 20 -> next cycle state IDLE, glyph_ready=1, busy=0. With DISP_HISTORY_BLINK_EN and BLINK_DIV=4, offset=0 -> window[6:0] alternates glyph/BLANK every 4 cycles.
